if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage; the producer side of the IF/ID pipeline register.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small queue and presents them as if_pc/if_inst.
- Honours downstream stall and redirects the PC on branch/jump, discarding wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset (bits [1:0] must be 0).
- QUEUE_DEPTH, 2, instruction queue entries (power of two, >=2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets immediately, independent of clk).
- if_stall  in  1  downstream hold; 1 = ID did not take the presented instruction.
- redirect_en  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
- mem_req  out  1  fetch request (registered).
- mem_addr  out  32  fetch word address (registered, stable while mem_req=1).
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; at most one per granted request, no earlier than the cycle after gnt.
- mem_rdata  in  32  instruction word.
- if_pc  out  32  PC of presented instruction.
- if_inst  out  32  presented instruction.
- if_valid  out  1  queue head valid.

Behaviour:
- Reset (async, rst=0):
  - pc=RESET_PC; state=IDLE; queue empty; discard=0.
  - mem_req=0; mem_addr=0.
  - Outputs: if_valid=0, if_pc=ZeroWord, if_inst=ZeroWord.
  - Reset mid-transaction abandons any outstanding fetch. The memory side must also be reset.
- Request FSM (at most one fetch outstanding):
  - IDLE -> REQ when (count + 0) < QUEUE_DEPTH and not redirect_en. Registers mem_req=1, mem_addr=pc.
  - REQ: mem_req/mem_addr held until mem_gnt. On gnt: pc<=pc+4 (wraps mod 2^32), mem_req<=0, -> WAIT.
  - WAIT: on mem_rvalid:
    - if discard=0: push {mem_addr_latched, mem_rdata}.
    - if discard=1: drop it and clear discard.
    - Then -> REQ if space remains after this cycle's push/pop and no redirect; else -> IDLE.
    - Space counts the entry being pushed, so the queue never overflows.
- Redirect (redirect_en=1, any state):
  - Queue flushed same cycle; flush beats a simultaneous pop.
  - pc<=redirect_pc&~3.
  - In REQ: request stays asserted at its old address until gnt (protocol rule). pc<=redirect_pc, discard<=1 at gnt, -> WAIT.
  - In WAIT: discard<=1. If rvalid arrives the same cycle, that response is dropped and discard stays 0.
  - In IDLE: only pc updates; the next request issues the cycle after.
  - Redirect while discard=1: discard stays 1.
- Output side (combinational from queue head):
  - if_valid = !empty.
  - if_pc/if_inst = head when valid, else ZeroWord/ZeroWord (bubble, matching the IF/ID clear value).
  - Pop when if_valid && !if_stall && !redirect_en.
  - Simultaneous push+pop: count unchanged; head advances.
  - Full: no new request issued until a pop.
- Throughput: 1-cycle memory gives one instruction every 2 cycles (REQ->WAIT->REQ). Rate is accepted; no pipelined requests.

Decomposition:
- defines.v (shared include): InstAddrBus, InstBus, ZeroWord, True/False (existing).
- Add FetchIdle/FetchReq/FetchWait 2-bit state codes and a FetchAlignMask constant to defines.v.
- Sub-module fetch_queue: synchronous FIFO of {pc,inst}.
  - Ports: push, pop, flush, count, head.
  - Async active-low reset.
  - Flush has priority over push/pop.

Test Plan:
- Reset release, memory with gnt same cycle and rvalid next cycle, if_stall=0:
  - mem_addr sequence 0x0,0x4,0x8.
  - if_pc/if_inst show each word one cycle after its rvalid, if_valid pulses.
  - Bubbles show ZeroWord.
- if_stall held 1 for 10 cycles from the first valid:
  - Queue fills to 2 and mem_req stays 0.
  - if_pc held at 0x0.
  - After release: 0x0,0x4 drain on consecutive cycles, then fetch of 0x8 resumes.
- redirect_en with redirect_pc=0x103 while in WAIT for 0x8:
  - 0x8's rvalid data is never presented.
  - Next mem_addr=0x100; queue empty the cycle after redirect.
- redirect during REQ with gnt delayed 3 cycles:
  - mem_addr stays at the old address until gnt.
  - That response is discarded; the next request is at redirect_pc.
- redirect_en coincident with mem_rvalid and a pending pop:
  - Nothing presented from the old path.
  - count=0, discard=0.
  - Next request is at the new PC.
- Assert rst=0 asynchronously mid-WAIT (between clock edges):
  - Outputs zero immediately.
  - After release, the first mem_addr equals RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// ============================================================================
// Module : if_fetch_pkg
// Brief  : Shared bus widths, fetch FSM codes and queue entry type for if_fetch.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package if_fetch_pkg;

  localparam int          InstAddrBus    = 32;
  localparam int          InstBus        = 32;
  localparam logic [31:0] ZeroWord       = 32'h0000_0000;
  localparam logic        True           = 1'b1;
  localparam logic        False          = 1'b0;

  localparam logic [1:0]  FetchIdle      = 2'b00;
  localparam logic [1:0]  FetchReq       = 2'b01;
  localparam logic [1:0]  FetchWait      = 2'b10;
  localparam logic [31:0] FetchAlignMask = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH_IDLE = FetchIdle,
    FETCH_REQ  = FetchReq,
    FETCH_WAIT = FetchWait
  } fetch_state_e;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  function automatic logic [InstAddrBus-1:0] align_pc(input logic [InstAddrBus-1:0] addr);
    return addr & FetchAlignMask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_queue.sv
// ============================================================================
// Module : if_fetch_queue
// Brief  : Small FIFO of {pc,inst} fetch results; flush wins over push/pop.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module if_fetch_queue
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  // A full queue may still accept a push when the head leaves in the same cycle.
  assign w_do_pop  = pop && (r_count != '0) && !flush;
  assign w_do_push = push && !flush && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// Module : if_fetch
// Brief  : Instruction fetch stage: PC, single-outstanding memory fetch, IF queue.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_stall,
  input  logic                    redirect_en,
  input  logic [InstAddrBus-1:0]  redirect_pc,
  output logic                    mem_req,
  output logic [InstAddrBus-1:0]  mem_addr,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [InstBus-1:0]      mem_rdata,
  output logic [InstAddrBus-1:0]  if_pc,
  output logic [InstBus-1:0]      if_inst,
  output logic                    if_valid
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e            r_state;
  fetch_state_e            w_state_nxt;
  logic [InstAddrBus-1:0]  r_pc;
  logic [InstAddrBus-1:0]  w_pc_nxt;
  logic [InstAddrBus-1:0]  r_mem_addr;
  logic [InstAddrBus-1:0]  w_mem_addr_nxt;
  logic                    r_mem_req;
  logic                    w_mem_req_nxt;
  logic                    r_discard;
  logic                    w_discard_nxt;

  logic [CW-1:0]           w_count;
  logic [CW-1:0]           w_count_after;
  fetch_entry_t            w_head;
  fetch_entry_t            w_push_data;
  logic                    w_valid;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_has_room;
  logic                    w_room_after;

  assign w_valid       = (w_count != '0) ? True : False;
  assign w_pop         = w_valid && !if_stall && !redirect_en;
  assign w_push        = (r_state == FETCH_WAIT) && mem_rvalid && !r_discard && !redirect_en;
  assign w_push_data   = {r_mem_addr, mem_rdata};
  assign w_has_room    = (w_count < CW'(QUEUE_DEPTH));
  // Occupancy after this cycle's push/pop decides whether the next fetch may start.
  assign w_count_after = redirect_en ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
  assign w_room_after  = (w_count_after < CW'(QUEUE_DEPTH));

  if_fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (redirect_en),
    .count     (w_count),
    .head      (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= FETCH_IDLE;
      r_pc       <= align_pc(RESET_PC);
      r_mem_req  <= 1'b0;
      r_mem_addr <= ZeroWord;
      r_discard  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_discard  <= w_discard_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_discard_nxt  = r_discard;

    if (redirect_en) w_pc_nxt = align_pc(redirect_pc);

    case (r_state)
      FETCH_IDLE: begin
        if (!redirect_en && w_has_room) begin
          w_state_nxt    = FETCH_REQ;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = r_pc;
        end
      end

      FETCH_REQ: begin
        // The in-flight request cannot be withdrawn; mark its response stale instead.
        if (redirect_en) w_discard_nxt = 1'b1;
        if (mem_gnt) begin
          w_state_nxt   = FETCH_WAIT;
          w_mem_req_nxt = 1'b0;
          if (!redirect_en && !r_discard) w_pc_nxt = r_pc + 32'd4;
        end
      end

      FETCH_WAIT: begin
        if (mem_rvalid) begin
          w_discard_nxt = 1'b0;
          if (w_room_after && !redirect_en) begin
            w_state_nxt    = FETCH_REQ;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = r_pc;
          end else begin
            w_state_nxt    = FETCH_IDLE;
          end
        end else if (redirect_en) begin
          w_discard_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt   = FETCH_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign if_valid = w_valid;
  assign if_pc    = w_valid ? w_head.pc   : ZeroWord;
  assign if_inst  = w_valid ? w_head.inst : ZeroWord;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// Module : tb_if_fetch
// Brief  : Randomized bench for if_fetch with memory model and in-order PC scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        if_stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int checks = 0;
  int errors = 0;
  int consumed = 0;

  // memory model state
  logic        pend;
  logic [31:0] pend_addr;
  int          rv_cnt, g_cnt;
  logic        req_seen;
  int          gnt_min = 0, gnt_max = 0, rv_min = 0, rv_max = 0;

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  logic [31:0] req_log[$];

  if_fetch #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_stall    (if_stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_valid    (if_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #3;
  endtask

  // Instruction memory: random grant latency, one response per grant.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    pend = 1'b0; pend_addr = '0; rv_cnt = 0; g_cnt = 0; req_seen = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (!rst) begin
        pend = 1'b0;
        req_seen = 1'b0;
      end else if (pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = memfn(pend_addr);
          pend       = 1'b0;
        end else begin
          rv_cnt--;
        end
      end else if (mem_req) begin
        if (!req_seen) begin
          g_cnt = $urandom_range(gnt_max, gnt_min);
          req_seen = 1'b1;
        end
        if (g_cnt == 0) begin
          mem_gnt   = 1'b1;
          pend      = 1'b1;
          pend_addr = mem_addr;
          rv_cnt    = $urandom_range(rv_max, rv_min);
          req_seen  = 1'b0;
        end else begin
          g_cnt--;
        end
      end
    end
  end

  // Monitor: the presented stream must be consecutive words from the last redirect target.
  logic        prev_req, prev_gnt;
  logic [31:0] prev_addr;
  int          idle;
  initial begin
    prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0; idle = 0; exp_next = RESET_PC;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        exp_next = RESET_PC;
        while (exp_q.size() < 4) begin exp_q.push_back(exp_next); exp_next += 32'd4; end
        prev_req = 1'b0; prev_gnt = 1'b0; idle = 0;
        check(!if_valid && if_pc == '0 && if_inst == '0 && !mem_req, "reset_outputs",
              if_pc | if_inst | {31'b0, if_valid | mem_req}, 32'h0);
        continue;
      end
      if (if_valid) begin
        check(if_pc == exp_q[0], "head_pc", if_pc, exp_q[0]);
        check(if_inst == memfn(exp_q[0]), "head_inst", if_inst, memfn(exp_q[0]));
      end else begin
        check(if_pc == '0 && if_inst == '0, "bubble_zero", if_pc | if_inst, 32'h0);
      end
      if (if_valid && !if_stall && !redirect_en) begin
        void'(exp_q.pop_front());
        consumed++;
      end
      if (redirect_en) begin
        exp_q.delete();
        exp_next = redirect_pc & 32'hFFFF_FFFC;
      end
      while (exp_q.size() < 4) begin exp_q.push_back(exp_next); exp_next += 32'd4; end

      if (prev_req && !prev_gnt)
        check(mem_req && mem_addr == prev_addr, "req_hold", mem_addr, prev_addr);
      if (mem_req) begin
        check(mem_addr[1:0] == 2'b00, "addr_align", mem_addr, mem_addr & 32'hFFFF_FFFC);
        check(!(pend && !mem_gnt), "one_outstanding", {31'b0, pend}, 32'h0);
      end
      if (mem_req && mem_gnt) req_log.push_back(mem_addr);
      prev_req = mem_req; prev_gnt = mem_gnt; prev_addr = mem_addr;

      if (if_valid || redirect_en) idle = 0;
      else idle++;
      if (idle > 40) begin
        check(1'b0, "progress_watchdog", idle, 40);
        idle = 0;
      end
    end
  end

  task automatic do_reset;
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    req_log.delete();
  endtask

  initial begin
    int n;
    int logsz;
    logic [31:0] a;
    logic [31:0] rp;
    rst = 1'b0; if_stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;

    // Straight-line fetch with single-cycle memory.
    do_reset();
    repeat (10) tick();
    for (int i = 0; i < 3; i++)
      check(req_log.size() > i && req_log[i] == RESET_PC + 32'(4 * i), "seq_addr",
            (req_log.size() > i) ? req_log[i] : 32'hFFFF_FFFF, RESET_PC + 32'(4 * i));

    // Stall fills the queue and blocks further requests.
    do_reset();
    n = 0;
    while (!if_valid && n < 20) begin tick(); n++; end
    check(if_valid, "first_valid", {31'b0, if_valid}, 32'h1);
    for (int i = 0; i < 10; i++) begin if_stall = 1'b1; tick(); end
    check(!mem_req, "stall_no_req", {31'b0, mem_req}, 32'h0);
    check(if_valid && if_pc == RESET_PC, "stall_hold_pc", if_pc, RESET_PC);
    if_stall = 1'b0;
    rv_min = 2; rv_max = 2;
    tick();
    check(if_valid && if_pc == RESET_PC + 32'd4, "drain_second", if_pc, RESET_PC + 32'd4);
    n = 0;
    while (!mem_req && n < 10) begin tick(); n++; end
    check(mem_req && mem_addr == RESET_PC + 32'd8, "resume_addr", mem_addr, RESET_PC + 32'd8);

    // Redirect while waiting for the 0x8 response.
    n = 0;
    while (!(pend && !mem_req) && n < 20) begin tick(); n++; end
    logsz = req_log.size();
    redirect_en = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_en = 1'b0;
    check(!if_valid, "redir_wait_empty", {31'b0, if_valid}, 32'h0);
    n = 0;
    while (req_log.size() <= logsz && n < 20) begin tick(); n++; end
    check(req_log.size() > logsz && req_log[logsz] == 32'h100, "redir_wait_next",
          (req_log.size() > logsz) ? req_log[logsz] : 32'hFFFF_FFFF, 32'h100);

    // Redirect during a request whose grant is delayed.
    gnt_min = 3; gnt_max = 3; rv_min = 0; rv_max = 0;
    n = 0;
    while (mem_req && n < 30) begin tick(); n++; end
    while (!mem_req && n < 60) begin tick(); n++; end
    a = mem_addr;
    logsz = req_log.size();
    rp = 32'h0000_2000 + 32'($urandom_range(0, 255) << 2) + 32'($urandom_range(0, 3));
    redirect_en = 1'b1; redirect_pc = rp;
    tick();
    redirect_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check(mem_req && mem_addr == a, "redir_req_hold", mem_addr, a);
      tick();
    end
    n = 0;
    while (req_log.size() < logsz + 2 && n < 30) begin tick(); n++; end
    check(req_log.size() > logsz && req_log[logsz] == a, "redir_old_gnt",
          (req_log.size() > logsz) ? req_log[logsz] : 32'hFFFF_FFFF, a);
    check(req_log.size() > logsz + 1 && req_log[logsz+1] == (rp & 32'hFFFF_FFFC), "redir_new_req",
          (req_log.size() > logsz + 1) ? req_log[logsz+1] : 32'hFFFF_FFFF, rp & 32'hFFFF_FFFC);

    // Redirect coincident with a response and a pending pop.
    gnt_min = 0; gnt_max = 0;
    if_stall = 1'b1;
    n = 0;
    while (!(if_valid && mem_rvalid) && n < 30) begin tick(); n++; end
    check(if_valid && mem_rvalid, "coinc_setup", {30'b0, if_valid, mem_rvalid}, 32'h3);
    rp = 32'h0000_4000 + 32'($urandom_range(0, 255) << 2);
    logsz = req_log.size();
    if_stall = 1'b0; redirect_en = 1'b1; redirect_pc = rp;
    tick();
    redirect_en = 1'b0;
    check(!if_valid, "coinc_empty", {31'b0, if_valid}, 32'h0);
    n = 0;
    while (!if_valid && n < 20) begin tick(); n++; end
    check(req_log.size() > logsz && req_log[logsz] == rp, "coinc_next_req",
          (req_log.size() > logsz) ? req_log[logsz] : 32'hFFFF_FFFF, rp);
    check(if_valid && if_pc == rp, "coinc_first", if_pc, rp);

    // Asynchronous reset between clock edges while a fetch is outstanding.
    rv_min = 2; rv_max = 2;
    n = 0;
    while (!(pend && !mem_req) && n < 20) begin tick(); n++; end
    #1;
    rst = 1'b0;
    #0.5;
    check(!if_valid && if_pc == '0 && if_inst == '0 && !mem_req, "async_rst_out",
          if_pc | if_inst | {31'b0, if_valid | mem_req}, 32'h0);
    check(mem_addr == '0, "async_rst_addr", mem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    req_log.delete();
    rv_min = 0; rv_max = 0;
    n = 0;
    while (req_log.size() == 0 && n < 20) begin tick(); n++; end
    check(req_log.size() > 0 && req_log[0] == RESET_PC, "post_rst_addr",
          (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, RESET_PC);

    // Randomized traffic, including redirects near the top of the address space.
    gnt_min = 0; gnt_max = 3; rv_min = 0; rv_max = 3;
    for (int i = 0; i < 1500; i++) begin
      if_stall    = ($urandom_range(0, 99) < 30);
      redirect_en = ($urandom_range(0, 99) < 5);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
      tick();
    end
    if_stall = 1'b0; redirect_en = 1'b0;
    repeat (30) tick();
    check(consumed > 100, "throughput", consumed, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=%0t required=<500000", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
